// File: rtl/psum_acc.sv
// Multi-pass partial-sum accumulator: reads rows from an upstream FIFO, sums them lane-wise per row,
// then streams the buffer out. Define PSUM_ACC_RELU_EN to clamp negative output lanes to zero.
module psum_acc #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int rd_lat  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(depth):0] len,
  input  logic [3:0]             passes,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = $clog2(depth) + 1;
  localparam int AW = $clog2(depth);
  localparam int RW = col * psum_bw;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [3:0]        passes_q, passes_d;
  logic [LW-1:0]     iss_row_q, iss_row_d;
  logic [3:0]        iss_pass_q, iss_pass_d;
  logic [LW-1:0]     cap_row_q, cap_row_d;
  logic [3:0]        cap_pass_q, cap_pass_d;
  logic [LW-1:0]     out_idx_q, out_idx_d;
  logic [rd_lat-1:0] strb_q, strb_d;

  logic [RW-1:0]     acc_mem_q [depth];
  logic [RW-1:0]     cap_old;
  logic [RW-1:0]     cap_sum;
  logic [RW-1:0]     out_row;
  logic [LW-1:0]     last_row;
  logic              cap_en;

  // A strobe leaving the top of the shift register marks the cycle its read data is on ofifo_out.
  assign cap_en   = strb_q[rd_lat-1];
  assign last_row = len_q - LW'(1);
  assign busy     = (state_q != IDLE);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    passes_d   = passes_q;
    iss_row_d  = iss_row_q;
    iss_pass_d = iss_pass_q;
    cap_row_d  = cap_row_q;
    cap_pass_d = cap_pass_q;
    out_idx_d  = out_idx_q;
    ofifo_rd   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;

    if (cap_en) begin
      if (cap_row_q == last_row) begin
        cap_row_d  = '0;
        cap_pass_d = cap_pass_q + 4'd1;
      end else begin
        cap_row_d  = cap_row_q + LW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0 || passes == '0) begin
            state_d = DONE;
          end else begin
            len_d      = len;
            passes_d   = passes;
            iss_row_d  = '0;
            iss_pass_d = '0;
            cap_row_d  = '0;
            cap_pass_d = '0;
            out_idx_d  = '0;
            state_d    = READ;
          end
        end
      end
      READ: begin
        if (ofifo_valid && iss_row_q < len_q) begin
          ofifo_rd = 1'b1;
          if (iss_row_q == last_row) begin
            iss_row_d  = '0;
            iss_pass_d = iss_pass_q + 4'd1;
            if (iss_pass_q == passes_q - 4'd1) state_d = DRAIN;
          end else begin
            iss_row_d  = iss_row_q + LW'(1);
          end
        end
      end
      DRAIN: begin
        if (strb_q == '0) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx_q == last_row) state_d = DONE;
          else                       out_idx_d = out_idx_q + LW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    strb_d    = strb_q << 1;
    strb_d[0] = ofifo_rd;
  end

  // Lane-wise wrapping add of the captured row onto the stored partial sum.
  always_comb begin
    cap_old = acc_mem_q[cap_row_q[AW-1:0]];
    cap_sum = '0;
    for (int i = 0; i < col; i++) begin
      cap_sum[i*psum_bw +: psum_bw] = cap_old[i*psum_bw +: psum_bw] + ofifo_out[i*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out_row = acc_mem_q[out_idx_q[AW-1:0]];
    out     = '0;
    if (state_q == OUT) begin
      out = out_row;
`ifdef PSUM_ACC_RELU_EN
      for (int i = 0; i < col; i++) begin
        if (out_row[(i+1)*psum_bw-1]) out[i*psum_bw +: psum_bw] = '0;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      passes_q   <= '0;
      iss_row_q  <= '0;
      iss_pass_q <= '0;
      cap_row_q  <= '0;
      cap_pass_q <= '0;
      out_idx_q  <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      passes_q   <= passes_d;
      iss_row_q  <= iss_row_d;
      iss_pass_q <= iss_pass_d;
      cap_row_q  <= cap_row_d;
      cap_pass_q <= cap_pass_d;
      out_idx_q  <= out_idx_d;
      strb_q     <= strb_d;
    end
  end

  // NOTE: the buffer has no reset; pass 0 overwrites every row of a job before any row is read.
  always_ff @(posedge clk) begin
    if (cap_en && !reset) begin
      acc_mem_q[cap_row_q[AW-1:0]] <= (cap_pass_q == '0) ? ofifo_out : cap_sum;
    end
  end

endmodule
